// File: rtl/riscv_mu_hazard_ctrl_mc.sv
// Hazard, stall and flush controller for the riscv pipeline.
// Tracks in-flight memory transactions per channel, detects load-use hazards and stretches/defers flushes.
module riscv_mu_hazard_ctrl_mc #(
  parameter  int NUM_CH          = 2,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int BLOCKING        = 1,
  parameter  int REG_ADDR_W      = 5,
  parameter  int FLUSH_CYCLES    = 1,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       i_req_valid,
  input  logic [NUM_CH-1:0]       i_req_ready,
  input  logic [NUM_CH-1:0]       i_rsp_valid,
  input  logic [REG_ADDR_W-1:0]   i_id_rs1,
  input  logic [REG_ADDR_W-1:0]   i_id_rs2,
  input  logic [1:0]              i_id_rs_used,
  input  logic [REG_ADDR_W-1:0]   i_ex_rd,
  input  logic                    i_ex_mem_read,
  input  logic                    i_jump_branch,
  output logic                    o_stall_if,
  output logic                    o_stall_id,
  output logic                    o_stall_rd_reg,
  output logic                    o_stall_wr_reg,
  output logic                    o_stall_ex,
  output logic                    o_stall_mem,
  output logic                    o_bubble_ex,
  output logic                    o_flush_if,
  output logic                    o_flush_id,
  output logic                    o_flush_ex,
  output logic [NUM_CH*CNT_W-1:0] o_outstanding,
  output logic [1:0]              o_err
);

  localparam int FC_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] hs, stall_req, ovf_hit, unf_hit, cnt_flag;
  logic [1:0]        err_q;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              mem_busy, flush_active, rs1_hit, rs2_hit, lu_raw, load_use;

  assign hs        = i_req_valid & i_req_ready;
  assign stall_req = i_req_valid & ~i_req_ready;

  // Simultaneous accept and response cancel out; illegal moves hold the count and flag an error.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_hit = '0;
    unf_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hs[c] && !i_rsp_valid[c]) begin
        if (cnt_q[c] == CNT_MAX) ovf_hit[c] = 1'b1;
        else                     cnt_d[c]   = cnt_q[c] + CNT_W'(1);
      end else if (i_rsp_valid[c] && !hs[c]) begin
        if (cnt_q[c] == '0) unf_hit[c] = 1'b1;
        else                cnt_d[c]   = cnt_q[c] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_flag = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_flag[c] = (BLOCKING != 0) ? (cnt_d[c] != '0) : (cnt_d[c] == CNT_MAX);
    end
  end

  assign mem_busy     = (|cnt_flag) | (|stall_req);
  assign flush_active = !mem_busy && (i_jump_branch || flush_pend_q || (flush_cnt_q != '0));

  // A branch seen while memory is busy is remembered and issued on the first free cycle.
  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    flush_pend_d = flush_pend_q;
    if (!mem_busy) begin
      if (i_jump_branch || flush_pend_q) begin
        flush_cnt_d  = FLUSH_LOAD;
        flush_pend_d = 1'b0;
      end else if (flush_cnt_q != '0) begin
        flush_cnt_d = flush_cnt_q - FC_W'(1);
      end
    end else if (i_jump_branch) begin
      flush_pend_d = 1'b1;
    end
  end

  assign rs1_hit  = i_id_rs_used[0] && (i_id_rs1 == i_ex_rd);
  assign rs2_hit  = i_id_rs_used[1] && (i_id_rs2 == i_ex_rd);
  assign lu_raw   = i_ex_mem_read && (i_ex_rd != '0) && (rs1_hit || rs2_hit);
  assign load_use = lu_raw && !mem_busy && !flush_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      err_q        <= '0;
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
    end else if (enable) begin
      cnt_q        <= cnt_d;
      err_q        <= err_q | {|unf_hit, |ovf_hit};
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign o_stall_if     = mem_busy | load_use;
  assign o_stall_id     = mem_busy | load_use;
  assign o_stall_rd_reg = mem_busy | load_use;
  assign o_stall_wr_reg = mem_busy;
  assign o_stall_ex     = mem_busy;
  assign o_stall_mem    = mem_busy;
  assign o_bubble_ex    = load_use;
  assign o_flush_if     = flush_active;
  assign o_flush_id     = flush_active;
  assign o_flush_ex     = flush_active;
  assign o_outstanding  = cnt_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_riscv_mu_hazard_ctrl_mc.sv
// Testbench: a blocking (FLUSH_CYCLES=3) and a non-blocking (FLUSH_CYCLES=1) instance share stimulus
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_riscv_mu_hazard_ctrl_mc;

  localparam int NCH  = 2;
  localparam int MAXO = 4;
  localparam int RW   = 5;
  localparam int CW   = 3;
  localparam int OW   = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, ex_mem_read, jump;
  logic [1:0]    req_valid, req_ready, rsp_valid, rs_used;
  logic [RW-1:0] rs1, rs2, ex_rd;
  logic [OW-1:0] obs [2];

  int total = 0;
  int bad   = 0;
  int fl0, fl1;

  // obs layout: {stall if,id,rd,wr,ex,mem, bubble, flush if,id,ex, outstanding[5:0], err[1:0]}
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic s_if, s_id, s_rd, s_wr, s_ex, s_mem, bub, f_if, f_id, f_ex;
    logic [NCH*CW-1:0] outst;
    logic [1:0] err;
    riscv_mu_hazard_ctrl_mc #(
      .NUM_CH(NCH), .MAX_OUTSTANDING(MAXO), .BLOCKING(g == 0 ? 1 : 0),
      .REG_ADDR_W(RW), .FLUSH_CYCLES(g == 0 ? 3 : 1)
    ) u_dut (
      .clk(clk), .reset(reset), .enable(enable),
      .i_req_valid(req_valid), .i_req_ready(req_ready), .i_rsp_valid(rsp_valid),
      .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs_used(rs_used),
      .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_jump_branch(jump),
      .o_stall_if(s_if), .o_stall_id(s_id), .o_stall_rd_reg(s_rd), .o_stall_wr_reg(s_wr),
      .o_stall_ex(s_ex), .o_stall_mem(s_mem), .o_bubble_ex(bub),
      .o_flush_if(f_if), .o_flush_id(f_id), .o_flush_ex(f_ex),
      .o_outstanding(outst), .o_err(err)
    );
    assign obs[g] = {s_if, s_id, s_rd, s_wr, s_ex, s_mem, bub, f_if, f_id, f_ex, outst, err};
  end

  // Behavioural model: integer in-flight counts, remaining flush cycles, pending branch flag.
  int       m_cnt  [2][2];
  logic [1:0] m_err[2];
  int       m_left [2];
  bit       m_pend [2];
  int       blk    [2] = '{1, 0};
  int       fcy    [2] = '{3, 1};

  function automatic int next_cnt(int g, int c);
    bit hsk = req_valid[c] && req_ready[c];
    bit rsp = rsp_valid[c];
    if (hsk && !rsp) return (m_cnt[g][c] >= MAXO) ? m_cnt[g][c] : m_cnt[g][c] + 1;
    if (rsp && !hsk) return (m_cnt[g][c] <= 0) ? 0 : m_cnt[g][c] - 1;
    return m_cnt[g][c];
  endfunction

  function automatic bit busy(int g);
    bit b = 0;
    for (int c = 0; c < NCH; c++) begin
      if (blk[g] != 0) b |= (next_cnt(g, c) > 0);
      else             b |= (next_cnt(g, c) == MAXO);
      b |= req_valid[c] && !req_ready[c];
    end
    return b;
  endfunction

  function automatic logic [OW-1:0] expected(int g);
    bit bz = busy(g);
    bit fl = !bz && (jump || m_pend[g] || m_left[g] > 0);
    bit hz = ex_mem_read && (ex_rd != 0) &&
             ((rs_used[0] && rs1 == ex_rd) || (rs_used[1] && rs2 == ex_rd));
    bit lu = hz && !bz && !fl;
    bit fr = bz || lu;
    return {fr, fr, fr, bz, bz, bz, lu, fl, fl, fl,
            3'(m_cnt[g][1]), 3'(m_cnt[g][0]), m_err[g]};
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_cnt[g][0] = 0; m_cnt[g][1] = 0;
      m_err[g] = 2'b00; m_left[g] = 0; m_pend[g] = 0;
    end
  endtask

  task automatic model_update(int g);
    bit bz;
    int nxt [2];
    if (!enable) return;
    bz = busy(g);
    for (int c = 0; c < NCH; c++) begin
      bit hsk = req_valid[c] && req_ready[c];
      nxt[c] = next_cnt(g, c);
      if (hsk && !rsp_valid[c] && m_cnt[g][c] == MAXO) m_err[g][0] = 1'b1;
      if (rsp_valid[c] && !hsk && m_cnt[g][c] == 0)    m_err[g][1] = 1'b1;
    end
    if (!bz) begin
      if (jump || m_pend[g]) begin
        m_left[g] = fcy[g] - 1;
        m_pend[g] = 0;
      end else if (m_left[g] > 0) begin
        m_left[g]--;
      end
    end else if (jump) begin
      m_pend[g] = 1;
    end
    m_cnt[g][0] = nxt[0];
    m_cnt[g][1] = nxt[1];
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] r, input logic [1:0] rs,
                               input logic j, input logic mr, input logic [RW-1:0] rd,
                               input logic [RW-1:0] a1, input logic [RW-1:0] a2,
                               input logic [1:0] used);
    enable = 1'b1; req_valid = v; req_ready = r; rsp_valid = rs; jump = j;
    ex_mem_read = mr; ex_rd = rd; rs1 = a1; rs2 = a2; rs_used = used;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, '0, 2'b00);
  endtask

  task automatic checkOutput();
    for (int g = 0; g < 2; g++) begin
      logic [OW-1:0] e = expected(g);
      total++;
      if (obs[g] !== e) begin
        bad++;
        $display("[TB] FAIL model_dut%0d t=%0t actual=%h required=%h", g, $time, obs[g], e);
      end
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic tick_check();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic tick_advance();
    @(posedge clk);
    if (!reset) begin
      model_update(0);
      model_update(1);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    tick_check();
    check_lit("reset_dut0", obs[0], 0);
    check_lit("reset_dut1", obs[1], 0);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] outstanding counter on ch1");
    applyStimulus(2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    tick_check(); check_lit("t1_stall_t0", obs[0][17], 1); check_lit("t1_cnt_t0", obs[0][7:5], 0);
    tick_advance();
    idle();
    tick_check(); check_lit("t1_cnt_t1", obs[0][7:5], 1); check_lit("t1_stall_t1", obs[0][17], 1);
    tick_advance();
    tick_check(); tick_advance();
    applyStimulus(2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
    tick_check(); check_lit("t1_stall_t3", obs[0][17], 0); check_lit("t1_cnt_t3", obs[0][7:5], 1);
    tick_advance();
    idle();
    tick_check(); check_lit("t1_cnt_t4", obs[0][7:5], 0);
    tick_advance();

    $display("[TB] load-use hazard");
    applyStimulus(0, 0, 0, 0, 1, 5, 5, 0, 2'b01);
    tick_check(); check_lit("lu_bubble", obs[0][11], 1); check_lit("lu_stall_if", obs[0][17], 1);
    check_lit("lu_stall_ex", obs[0][13], 0);
    tick_advance();
    idle();
    tick_check(); check_lit("lu_bubble_gone", obs[0][11], 0);
    tick_advance();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 2'b01);
    tick_check(); check_lit("lu_x0_bubble", obs[0][11], 0); check_lit("lu_x0_stall", obs[0][17], 0);
    tick_advance();

    $display("[TB] flush stretch with simultaneous hazard");
    fl0 = 0; fl1 = 0;
    applyStimulus(0, 0, 0, 1, 1, 5, 5, 0, 2'b01);
    tick_check(); check_lit("fl_lu_suppressed", obs[0][11], 0); check_lit("fl_now", obs[0][10], 1);
    fl0 += obs[0][10]; fl1 += obs[1][10];
    tick_advance();
    idle();
    for (int i = 0; i < 4; i++) begin
      tick_check(); fl0 += obs[0][10]; fl1 += obs[1][10]; tick_advance();
    end
    check_lit("fl_len_dut0", fl0, 3);
    check_lit("fl_len_dut1", fl1, 1);

    $display("[TB] flush deferred behind memory stall");
    applyStimulus(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    tick_check(); tick_advance();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick_check(); check_lit("df_busy_dut0", obs[0][10], 0); check_lit("df_free_dut1", obs[1][10], 1);
    tick_advance();
    idle();
    tick_check(); check_lit("df_wait", obs[0][10], 0); tick_advance();
    applyStimulus(0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    tick_check(); check_lit("df_issue", obs[0][10], 1); check_lit("df_nostall", obs[0][17], 0);
    tick_advance();
    idle();
    tick_check(); tick_advance();
    tick_check(); tick_advance();
    tick_check(); check_lit("df_done", obs[0][10], 0); tick_advance();

    $display("[TB] overflow on ch0");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0);
      tick_check();
      if (i == 0) check_lit("ov_nb_stall0", obs[1][17], 0);
      if (i == 2) check_lit("ov_nb_stall2", obs[1][17], 0);
      if (i == 3) check_lit("ov_nb_stall3", obs[1][17], 1);
      tick_advance();
    end
    idle();
    tick_check(); check_lit("ov_err", obs[1][1:0], 2'b01); check_lit("ov_cnt", obs[1][4:2], 4);
    check_lit("ov_stall_mem", obs[1][12], 1);
    tick_advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
      tick_check(); tick_advance();
    end

    $display("[TB] underflow and reset mid-stall");
    applyStimulus(0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    tick_check(); tick_advance();
    idle();
    tick_check(); check_lit("uf_err", obs[0][1:0], 2'b11); check_lit("uf_cnt", obs[0][7:5], 0);
    tick_advance();
    applyStimulus(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    tick_check(); tick_advance();
    idle();
    tick_check(); check_lit("rst_pre_stall", obs[0][17], 1);
    #1 reset = 1'b1;
    model_reset();
    #1;
    checkOutput();
    check_lit("rst_async_dut0", obs[0], 0);
    check_lit("rst_async_dut1", obs[1], 0);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus({$urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3},
                    {$urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7},
                    {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
                    $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                    RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                    RW'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      tick_check();
      tick_advance();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
